// File: rtl/isqrt_arb_pkg.sv
// Shared widths and the round-robin pick helper for the isqrt arbiter slice.
package isqrt_arb_pkg;

    localparam int ISQRT_X_W   = 32;
    localparam int ISQRT_Y_W   = 16;
    localparam int MAX_CLIENTS = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of vld at or above ptr, wrapping modulo n (n <= MAX_CLIENTS).
    function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] vld,
                                         input logic [3:0]             ptr,
                                         input int                     n);
        rr_pick_t   r;
        logic [4:0] c;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int k = 0; k < MAX_CLIENTS; k++) begin
            c = {1'b0, ptr} + 5'(k);
            if (c >= 5'(n)) begin
                c = c - 5'(n);
            end else begin
                c = c;
            end
            if ((k < n) && !r.found && vld[c[3:0]]) begin
                r.found = 1'b1;
                r.idx   = c[3:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/isqrt_rr_arbiter_if.sv
// Client-side request/response bundle of the shared isqrt arbiter.
interface isqrt_rr_arbiter_if #(
    parameter int N_CLIENTS = 4
);
    import isqrt_arb_pkg::*;

    logic [N_CLIENTS-1:0]           req_vld;
    logic [ISQRT_X_W*N_CLIENTS-1:0] req_x;
    logic [N_CLIENTS-1:0]           req_rdy;
    logic [N_CLIENTS-1:0]           rsp_vld;
    logic [ISQRT_Y_W-1:0]           rsp_y;

    modport master (output req_vld, req_x, input req_rdy, rsp_vld, rsp_y);
    modport slave  (input req_vld, req_x, output req_rdy, rsp_vld, rsp_y);

endinterface

// File: rtl/isqrt_tag_fifo.sv
// In-order tag FIFO; push and pop may coincide even when full or empty.
module isqrt_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state pointers and occupancy; a pop on a full FIFO makes room for the push.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one in-order isqrt pipe; results are steered back by tag.
module isqrt_rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_CLIENTS       = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    isqrt_rr_arbiter_if.slave    cli,
    output logic                 isqrt_x_vld,
    output logic [ISQRT_X_W-1:0] isqrt_x,
    input  logic                 isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0] isqrt_y,
    output logic                 busy,
    output logic                 err_orphan
);

    localparam int TAG_W = $clog2(N_CLIENTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    rr_pick_t             pick_s;
    logic                 gnt_vld_s, pop_s;
    logic [TAG_W-1:0]     gnt_idx_s, head_s;
    logic [N_CLIENTS-1:0] req_rdy_s;
    logic [ISQRT_X_W-1:0] x_arr_s [N_CLIENTS];
    logic                 fifo_empty_s, fifo_full_s;
    logic [CNT_W-1:0]     fifo_count_s;

    logic [TAG_W-1:0]     ptr_q, ptr_d;
    logic                 isqrt_x_vld_q, isqrt_x_vld_d;
    logic [ISQRT_X_W-1:0] isqrt_x_q, isqrt_x_d;
    logic [N_CLIENTS-1:0] rsp_vld_q, rsp_vld_d;
    logic [ISQRT_Y_W-1:0] rsp_y_q, rsp_y_d;
    logic                 err_orphan_q, err_orphan_d;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_x
        assign x_arr_s[i] = cli.req_x[ISQRT_X_W*i +: ISQRT_X_W];
    end

    // Grant: a full FIFO blocks even if a pop is happening this same cycle.
    always_comb begin
        pick_s    = rr_pick(MAX_CLIENTS'(cli.req_vld), 4'(ptr_q), N_CLIENTS);
        gnt_vld_s = pick_s.found && !fifo_full_s && (pick_s.idx < 4'(N_CLIENTS));
        gnt_idx_s = pick_s.idx[TAG_W-1:0];
        req_rdy_s = '0;
        if (gnt_vld_s) begin
            req_rdy_s[gnt_idx_s] = 1'b1;
        end else begin
            req_rdy_s = '0;
        end
    end

    // Next state of pointer, isqrt issue, response steering and orphan flag.
    always_comb begin
        pop_s        = isqrt_y_vld && !fifo_empty_s;
        rsp_vld_d    = '0;
        err_orphan_d = err_orphan_q | (isqrt_y_vld & fifo_empty_s);
        if (gnt_vld_s) begin
            ptr_d     = (gnt_idx_s == TAG_W'(N_CLIENTS - 1)) ? '0 : gnt_idx_s + TAG_W'(1);
            isqrt_x_d = x_arr_s[gnt_idx_s];
        end else begin
            ptr_d     = ptr_q;
            isqrt_x_d = isqrt_x_q;
        end
        isqrt_x_vld_d = gnt_vld_s;
        if (pop_s) begin
            rsp_vld_d[head_s] = 1'b1;
            rsp_y_d           = isqrt_y;
        end else begin
            rsp_y_d = rsp_y_q;
        end
    end

    // Output and arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            isqrt_x_vld_q <= 1'b0;
            isqrt_x_q     <= '0;
            rsp_vld_q     <= '0;
            rsp_y_q       <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            isqrt_x_vld_q <= isqrt_x_vld_d;
            isqrt_x_q     <= isqrt_x_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_y_q       <= rsp_y_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    isqrt_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gnt_vld_s),
        .push_data (gnt_idx_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign cli.req_rdy  = req_rdy_s;
    assign cli.rsp_vld  = rsp_vld_q;
    assign cli.rsp_y    = rsp_y_q;
    assign isqrt_x_vld  = isqrt_x_vld_q;
    assign isqrt_x      = isqrt_x_q;
    assign busy         = (fifo_count_s != '0);
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: 4-cycle isqrt pipe model, scoreboard of expected responses.
module tb_isqrt_rr_arbiter;

    typedef struct {
        int          cli;
        logic [15:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q1[$];
    exp_t q2[$];

    isqrt_rr_arbiter_if #(.N_CLIENTS(4)) if1 ();
    isqrt_rr_arbiter_if #(.N_CLIENTS(4)) if2 ();

    logic        xv1, xv2, yv1, yv2, busy1, busy2, err1, err2;
    logic [31:0] x1, x2;
    logic [15:0] y1, y2;
    logic        inj_vld = 1'b0;
    logic [15:0] inj_y   = 16'd0;

    isqrt_rr_arbiter #(.N_CLIENTS(4), .MAX_OUTSTANDING(16)) dut1 (
        .clk(clk), .rst(rst), .cli(if1), .isqrt_x_vld(xv1), .isqrt_x(x1),
        .isqrt_y_vld(yv1), .isqrt_y(y1), .busy(busy1), .err_orphan(err1));

    isqrt_rr_arbiter #(.N_CLIENTS(4), .MAX_OUTSTANDING(2)) dut2 (
        .clk(clk), .rst(rst), .cli(if2), .isqrt_x_vld(xv2), .isqrt_x(x2),
        .isqrt_y_vld(yv2), .isqrt_y(y2), .busy(busy2), .err_orphan(err2));

    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return 16'(r);
    endfunction

    // Fixed 4-cycle isqrt pipes, not reset, so in-flight work survives a DUT reset.
    logic [3:0]  p1_vld = 4'b0000;
    logic [3:0]  p2_vld = 4'b0000;
    logic [15:0] p1_y [4];
    logic [15:0] p2_y [4];
    always @(posedge clk) begin
        p1_vld  <= {p1_vld[2:0], xv1};
        p2_vld  <= {p2_vld[2:0], xv2};
        p1_y[0] <= isqrt_ref(x1);
        p2_y[0] <= isqrt_ref(x2);
        for (int k = 1; k < 4; k++) begin
            p1_y[k] <= p1_y[k-1];
            p2_y[k] <= p2_y[k-1];
        end
    end
    assign yv1 = p1_vld[3] | inj_vld;
    assign y1  = inj_vld ? inj_y : p1_y[3];
    assign yv2 = p2_vld[3];
    assign y2  = p2_y[3];

    task automatic sb_check;
        exp_t e;
        if (if1.rsp_vld !== 4'b0000) begin
            n_checks++;
            if (q1.size() == 0) begin
                $display("FAIL sb1_unexpected: got rsp_vld=%b y=%0d, want no response", if1.rsp_vld, if1.rsp_y);
            end else begin
                e = q1.pop_front();
                if ({if1.rsp_vld, if1.rsp_y} !== {4'b0001 << e.cli, e.y})
                    $display("FAIL sb1_rsp: got rsp_vld=%b y=%0d, want %b y=%0d", if1.rsp_vld, if1.rsp_y, 4'b0001 << e.cli, e.y);
                else n_pass++;
            end
        end
        if (if2.rsp_vld !== 4'b0000) begin
            n_checks++;
            if (q2.size() == 0) begin
                $display("FAIL sb2_unexpected: got rsp_vld=%b y=%0d, want no response", if2.rsp_vld, if2.rsp_y);
            end else begin
                e = q2.pop_front();
                if ({if2.rsp_vld, if2.rsp_y} !== {4'b0001 << e.cli, e.y})
                    $display("FAIL sb2_rsp: got rsp_vld=%b y=%0d, want %b y=%0d", if2.rsp_vld, if2.rsp_y, 4'b0001 << e.cli, e.y);
                else n_pass++;
            end
        end
    endtask

    task automatic tick;
        @(negedge clk);
        sb_check();
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        if1.req_vld = 4'b0000;
        if2.req_vld = 4'b0000;
        tick(); step();
        tick(); step();
        rst = 1'b0;
        q1.delete();
        q2.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (busy1 || busy2 || q1.size() != 0 || q2.size() != 0); i++) begin
            tick(); step();
        end
        n_checks++;
        if ({busy1, busy2, q1.size() != 0, q2.size() != 0} !== 4'b0000)
            $display("FAIL %s_drain: got busy1=%b busy2=%b pending=%0d/%0d, want idle", name, busy1, busy2, q1.size(), q2.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        n_checks++;
        if ({if1.req_rdy, if1.rsp_vld, if1.rsp_y, xv1, x1, busy1, err1} !== 59'd0)
            $display("FAIL reset_dut1: got rdy=%b rsp=%b y=%0d xv=%b x=%0d busy=%b err=%b, want all 0",
                     if1.req_rdy, if1.rsp_vld, if1.rsp_y, xv1, x1, busy1, err1);
        else n_pass++;
        n_checks++;
        if ({if2.req_rdy, if2.rsp_vld, if2.rsp_y, xv2, x2, busy2, err2} !== 59'd0)
            $display("FAIL reset_dut2: got rdy=%b rsp=%b y=%0d xv=%b x=%0d busy=%b err=%b, want all 0",
                     if2.req_rdy, if2.rsp_vld, if2.rsp_y, xv2, x2, busy2, err2);
        else n_pass++;
        step();
    endtask

    task automatic test_single;
        if1.req_x[31:0] = 32'd144;
        if1.req_vld     = 4'b0001;
        q1.push_back('{0, 16'd12});
        tick();
        n_checks++;
        if (if1.req_rdy !== 4'b0001) $display("FAIL single_grant: got %b want 0001", if1.req_rdy);
        else n_pass++;
        step();
        if1.req_vld = 4'b0000;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if ({xv1, x1} !== {1'b1, 32'd144}) $display("FAIL single_issue: got xv=%b x=%0d want 1 144", xv1, x1);
                else n_pass++;
            end
            n_checks++;
            if (c <= 5) begin
                if ({busy1, if1.rsp_vld} !== 5'b10000) $display("FAIL single_busy c%0d: got busy=%b rsp=%b want 1 0000", c, busy1, if1.rsp_vld);
                else n_pass++;
            end else begin
                if ({if1.rsp_vld, if1.rsp_y, busy1} !== {4'b0001, 16'd12, 1'b0})
                    $display("FAIL single_rsp: got rsp=%b y=%0d busy=%b want 0001 12 0", if1.rsp_vld, if1.rsp_y, busy1);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_all_four;
        do_reset();
        if1.req_x   = {32'd49, 32'd36, 32'd25, 32'd16};
        if1.req_vld = 4'b1111;
        for (int k = 0; k < 4; k++) q1.push_back('{k, 16'(4 + k)});
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c < 4) begin
                n_checks++;
                if (if1.req_rdy !== (4'b0001 << c)) $display("FAIL all4_grant c%0d: got %b want %b", c, if1.req_rdy, 4'b0001 << c);
                else n_pass++;
            end else if (c >= 6) begin
                n_checks++;
                if (if1.rsp_vld !== (4'b0001 << (c - 6))) $display("FAIL all4_rsp_time c%0d: got %b want %b", c, if1.rsp_vld, 4'b0001 << (c - 6));
                else n_pass++;
            end
            step();
            if (c < 4) if1.req_vld[c] = 1'b0;
        end
        wait_drain("all4");
    endtask

    task automatic test_alternate;
        logic [3:0] exp_rdy;
        do_reset();
        if1.req_x[31:0]  = 32'd400;
        if1.req_x[95:64] = 32'd900;
        if1.req_vld      = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_rdy = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            if (c % 2 == 0) q1.push_back('{0, 16'd20});
            else            q1.push_back('{2, 16'd30});
            n_checks++;
            if (if1.req_rdy !== exp_rdy) $display("FAIL alt_grant c%0d: got %b want %b", c, if1.req_rdy, exp_rdy);
            else n_pass++;
            step();
        end
        if1.req_vld = 4'b0000;
        wait_drain("alt");
    endtask

    task automatic test_stall;
        logic [3:0] exp_rdy;
        do_reset();
        if2.req_x[63:32] = 32'd1;
        if2.req_vld      = 4'b0010;
        q2.push_back('{1, 16'd1});
        q2.push_back('{1, 16'd2});
        q2.push_back('{1, 16'd3});
        for (int c = 0; c < 14; c++) begin
            tick();
            exp_rdy = (c == 0 || c == 1 || c == 6) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (if2.req_rdy !== exp_rdy) $display("FAIL stall_grant c%0d: got %b want %b", c, if2.req_rdy, exp_rdy);
            else n_pass++;
            step();
            if (c == 0) if2.req_x[63:32] = 32'd4;
            if (c == 1) if2.req_x[63:32] = 32'd9;
            if (c == 6) if2.req_vld = 4'b0000;
        end
        wait_drain("stall");
    endtask

    task automatic test_orphan;
        do_reset();
        inj_vld = 1'b1;
        inj_y   = 16'd7;
        tick();
        n_checks++;
        if (err1 !== 1'b0) $display("FAIL orphan_before: got err=%b want 0", err1);
        else n_pass++;
        step();
        inj_vld = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            n_checks++;
            if ({err1, if1.rsp_vld} !== 5'b10000) $display("FAIL orphan_sticky c%0d: got err=%b rsp=%b want 1 0000", c, err1, if1.rsp_vld);
            else n_pass++;
            step();
        end
        do_reset();
        tick();
        n_checks++;
        if (err1 !== 1'b0) $display("FAIL orphan_cleared: got err=%b want 0", err1);
        else n_pass++;
        step();
    endtask

    task automatic test_mid_reset;
        do_reset();
        if1.req_x[31:0] = 32'd81;
        if1.req_vld     = 4'b0001;
        tick();
        n_checks++;
        if (if1.req_rdy !== 4'b0001) $display("FAIL midrst_grant: got %b want 0001", if1.req_rdy);
        else n_pass++;
        step();
        if1.req_vld = 4'b0000;
        tick(); step();
        rst = 1'b1;
        tick(); step();
        rst = 1'b0;
        q1.delete();
        tick();
        n_checks++;
        if ({if1.req_rdy, if1.rsp_vld, if1.rsp_y, xv1, x1, busy1, err1} !== 59'd0)
            $display("FAIL midrst_values: got rdy=%b rsp=%b y=%0d xv=%b x=%0d busy=%b err=%b, want all 0",
                     if1.req_rdy, if1.rsp_vld, if1.rsp_y, xv1, x1, busy1, err1);
        else n_pass++;
        step();
        tick(); step();
        tick();
        n_checks++;
        if ({err1, yv1} !== 2'b01) $display("FAIL midrst_pre_orphan: got err=%b yv=%b want 0 1", err1, yv1);
        else n_pass++;
        step();
        tick();
        n_checks++;
        if ({err1, if1.rsp_vld} !== 5'b10000) $display("FAIL midrst_orphan: got err=%b rsp=%b want 1 0000", err1, if1.rsp_vld);
        else n_pass++;
        step();
        if1.req_x[31:0] = 32'd100;
        if1.req_vld     = 4'b0001;
        q1.push_back('{0, 16'd10});
        tick();
        n_checks++;
        if (if1.req_rdy !== 4'b0001) $display("FAIL midrst_regrant: got %b want 0001", if1.req_rdy);
        else n_pass++;
        step();
        if1.req_vld = 4'b0000;
        wait_drain("midrst");
        n_checks++;
        if (err1 !== 1'b1) $display("FAIL midrst_err_hold: got %b want 1", err1);
        else n_pass++;
    endtask

    initial begin
        if1.req_vld = 4'b0000;
        if1.req_x   = '0;
        if2.req_vld = 4'b0000;
        if2.req_x   = '0;
        step();
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_stall();
        test_orphan();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
